circuit_sweep_ctrl: RTL and testbench
=====================================

CIRCUIT_SWEEP_CTRL -- requirements
Module: circuit_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 start  input  1  request to begin a sweep; sampled only in IDLE.
REQ-003 abort  input  1  terminate an active sweep.
REQ-004 X  input  1  first output of the combinational circuit under sequence.
REQ-005 Y  input  1  second output of the combinational circuit under sequence.
REQ-006 expected  input  16  golden {X,Y} pairs; bits [2v+1:2v] = {X,Y} for vector v.
REQ-007 A, B, C  output  1 each  registered stimulus to the circuit; {A,B,C} = vector index v.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on sweep completion.
REQ-010 result  output  16  captured {X,Y} pairs, same packing as expected.
REQ-011 mismatch_cnt  output  4  number of vectors whose captured pair differs from expected (0..8).
REQ-012 pass  output  1  high when the last completed sweep had mismatch_cnt = 0.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SETTLE (macro only), SAMPLE and DONE.
REQ-014 IDLE: {A,B,C} = 000; start = 1 -> DRIVE with v = 0; result, mismatch_cnt and pass cleared at the same edge.
REQ-015 DRIVE: {A,B,C} registered to v; next state SAMPLE (or SETTLE when enabled).
REQ-016 SAMPLE: result[2v+1:2v] <= {X,Y}; mismatch_cnt += 1 if {X,Y} != expected[2v+1:2v].
REQ-017 SAMPLE: if v = 7 -> DONE, else v += 1 -> DRIVE; v is 3 bits and never wraps inside a sweep.
REQ-018 DONE: done = 1 for exactly one cycle; pass <= (mismatch_cnt == 0); next state IDLE.
REQ-019 Latency with macro off: 2 cycles per vector; start sampled at edge 0 -> done high during cycle 17.
REQ-020 start while busy SHALL be ignored; start held high across DONE re-arms only from IDLE, one cycle later.
REQ-021 abort in DRIVE/SETTLE/SAMPLE SHALL go to IDLE next edge.
REQ-022 On abort, done is not pulsed, pass stays 0, and result/mismatch_cnt keep partial values.
REQ-023 abort and start together in IDLE: start wins; abort in DONE: ignored (done still pulses).
REQ-024 expected SHALL be sampled per vector in SAMPLE; it must be held stable by the user for the whole sweep.
REQ-025 result, mismatch_cnt and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-026 rst = 1 at a clock edge SHALL force IDLE, v = 0, {A,B,C} = 000, busy = 0, done = 0, result = 0, mismatch_cnt = 0, pass = 0.
REQ-027 rst SHALL override start and abort, including mid-sweep.

Configuration
REQ-028 Macro SWEEP_SETTLE_EN defined: SETTLE state inserted between DRIVE and SAMPLE, holding {A,B,C}; 3 cycles per vector; done high during cycle 25.
REQ-029 SWEEP_SETTLE_EN undefined: no SETTLE state; DRIVE goes directly to SAMPLE; timing per REQ-019.

Verification
REQ-030 The bench model SHALL be X = A^B^C and Y = majority(A,B,C); with expected = 16'hD668, pulse start -> result = 16'hD668, mismatch_cnt = 0, pass = 1, done in cycle 17.
REQ-031 Same model, expected = 16'hD669 -> mismatch_cnt = 1, pass = 0, result = 16'hD668.
REQ-032 expected = 16'h0000 with the same model -> mismatch_cnt = 7, pass = 0.
REQ-033 abort in the SAMPLE cycle of v = 3 -> IDLE next cycle, no done pulse, result[7:0] = 8'h68, upper bits 0.
REQ-034 rst asserted mid-sweep at v = 5, then start -> all outputs zero after rst; the full sweep then reproduces REQ-030.
REQ-035 Build with SWEEP_SETTLE_EN -> the REQ-030 stimulus gives done in cycle 25 and an identical result.

Source files
------------

// File: rtl/circuit_sweep_ctrl_if.sv
// Bundle of sweep-control signals between the sweep controller and its user.
// No latency of its own; pure wiring.
// No backpressure; start/abort are level requests sampled by the controller.
interface circuit_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        X;
  logic        Y;
  logic [15:0] expected;
  logic        A;
  logic        B;
  logic        C;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  mismatch_cnt;
  logic        pass;

  // User side: issues requests, returns circuit outputs, observes status.
  modport master (
    output start, abort, X, Y, expected,
    input  A, B, C, busy, done, result, mismatch_cnt, pass
  );

  // Controller side.
  modport slave (
    input  start, abort, X, Y, expected,
    output A, B, C, busy, done, result, mismatch_cnt, pass
  );
endinterface

// File: rtl/circuit_sweep_ctrl.sv
// Sweeps {A,B,C} through 0..7, captures {X,Y} per vector and counts mismatches vs. expected.
// 2 cycles per vector (3 with SWEEP_SETTLE_EN defined); start at edge 0 -> done in cycle 17 (25).
// No backpressure: start ignored while busy, abort drops to IDLE keeping partial results.
module circuit_sweep_ctrl (
  input logic              clk,
  input logic              rst,
  circuit_sweep_ctrl_if.slave bus
);

`ifdef SWEEP_SETTLE_EN
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
`endif

  state_t      state;
  state_t      next_state;
  logic [2:0]  v;
  logic [2:0]  next_v;
  logic [2:0]  abc;
  logic [15:0] result_q;
  logic [3:0]  mismatch_q;
  logic        pass_q;
  logic [1:0]  sample_pair;
  logic [1:0]  golden_pair;

  assign sample_pair = {bus.X, bus.Y};
  assign golden_pair = bus.expected[{v, 1'b0} +: 2];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and next vector index; abort wins only in the active sweep states.
  always_comb begin
    next_state = state;
    next_v     = v;
    case (state)
      IDLE: begin
        next_v = 3'd0;
        if (bus.start) next_state = DRIVE;
      end
      DRIVE: begin
`ifdef SWEEP_SETTLE_EN
        next_state = bus.abort ? IDLE : SETTLE;
`else
        next_state = bus.abort ? IDLE : SAMPLE;
`endif
      end
`ifdef SWEEP_SETTLE_EN
      SETTLE: begin
        next_state = bus.abort ? IDLE : SAMPLE;
      end
`endif
      SAMPLE: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (v == 3'd7) begin
          next_state = DONE;
        end else begin
          next_state = DRIVE;
          next_v     = v + 3'd1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the current state; stimulus and results come from registers.
  always_comb begin
    bus.busy         = (state != IDLE);
    bus.done         = (state == DONE);
    {bus.A, bus.B, bus.C} = abc;
    bus.result       = result_q;
    bus.mismatch_cnt = mismatch_q;
    bus.pass         = pass_q;
  end

  // Datapath: vector index, registered stimulus, captured results and verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      v          <= 3'd0;
      abc        <= 3'd0;
      result_q   <= 16'd0;
      mismatch_q <= 4'd0;
      pass_q     <= 1'b0;
    end else begin
      v   <= next_v;
      // Stimulus returns to 000 whenever the controller goes idle.
      abc <= (next_state == IDLE) ? 3'd0 : next_v;
      case (state)
        IDLE: begin
          if (bus.start) begin
            result_q   <= 16'd0;
            mismatch_q <= 4'd0;
            pass_q     <= 1'b0;
          end
        end
        SAMPLE: begin
          // The sample is taken even when abort arrives in this cycle.
          result_q[{v, 1'b0} +: 2] <= sample_pair;
          if (sample_pair != golden_pair) mismatch_q <= mismatch_q + 4'd1;
        end
        DONE:    pass_q <= (mismatch_q == 4'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Bench for circuit_sweep_ctrl: directed sweeps with literal expectations plus
// randomized start/abort/rst traffic checked every cycle against a counter-based model.
module tb_circuit_sweep_ctrl;
`ifdef SWEEP_SETTLE_EN
  localparam int PER = 3;
`else
  localparam int PER = 2;
`endif
  localparam int LAST = 8 * PER + 1;           // cycle index of the done pulse
  localparam logic [15:0] CANON = 16'hD668;    // X = A^B^C, Y = majority(A,B,C)

  logic clk = 1'b0;
  logic rst;
  logic [15:0] circ;                           // truth table of the circuit under sequence

  circuit_sweep_ctrl_if bus ();

  circuit_sweep_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Circuit under sequence: pair for vector {A,B,C} taken from the truth table.
  assign {bus.X, bus.Y} = circ[{bus.A, bus.B, bus.C, 1'b0} +: 2];

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: m_k = cycle number within the sweep (0 = idle).
  int          m_k = 0;
  int          m_mm = 0;
  logic [15:0] m_res = 16'd0;
  logic        m_pass = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    int mv;
    logic [1:0] pr;
    if (rst) begin
      m_k = 0; m_res = 16'd0; m_mm = 0; m_pass = 1'b0; m_valid = 1'b1;
    end else if (m_k == 0) begin
      if (bus.start) begin
        m_k = 1; m_res = 16'd0; m_mm = 0; m_pass = 1'b0;
      end
    end else if (m_k == LAST) begin
      m_pass = (m_mm == 0);
      m_k = 0;
    end else begin
      mv = (m_k - 1) / PER;
      if ((m_k - 1) % PER == PER - 1) begin
        pr = circ[2*mv +: 2];
        m_res[2*mv +: 2] = pr;
        if (pr != bus.expected[2*mv +: 2]) m_mm++;
      end
      if (bus.abort) m_k = 0;
      else m_k++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 16'(bus.busy), 16'(m_k != 0));
      chk("done", 16'(bus.done), 16'(m_k == LAST));
      chk("result", bus.result, m_res);
      chk("mismatch_cnt", 16'(bus.mismatch_cnt), 16'(m_mm));
      chk("pass", 16'(bus.pass), 16'(m_pass));
      if (m_k == 0)
        chk("abc_idle", 16'({bus.A, bus.B, bus.C}), 16'd0);
      else if (m_k < LAST)
        chk("abc_vector", 16'({bus.A, bus.B, bus.C}), 16'((m_k - 1) / PER));
    end
  end

  task automatic run_sweep(input logic [15:0] exp_v, input logic [15:0] want_res,
                           input logic [3:0] want_mm, input logic want_pass);
    int n;
    bus.expected = exp_v;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      tick;
      n++;
    end
    chk("done_cycle", 16'(n), 16'(LAST));
    tick;
    chk("sweep_result", bus.result, want_res);
    chk("sweep_mismatch", 16'(bus.mismatch_cnt), 16'(want_mm));
    chk("sweep_pass", 16'(bus.pass), 16'(want_pass));
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.expected = 16'd0;
    circ = CANON;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_result", bus.result, 16'd0);
    chk("rst_mismatch", 16'(bus.mismatch_cnt), 16'd0);
    chk("rst_pass", 16'(bus.pass), 16'd0);
    chk("rst_abc", 16'({bus.A, bus.B, bus.C}), 16'd0);

    // Golden match, single mismatch at vector 0, all-zero golden (7 nonzero pairs).
    run_sweep(16'hD668, 16'hD668, 4'd0, 1'b1);
    run_sweep(16'hD669, 16'hD668, 4'd1, 1'b0);
    run_sweep(16'h0000, 16'hD668, 4'd7, 1'b0);

    // Abort in the SAMPLE cycle of vector 3.
    bus.expected = 16'hD668;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (4 * PER - 1) tick;
    chk("abort_pre_busy", 16'(bus.busy), 16'd1);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    chk("abort_busy", 16'(bus.busy), 16'd0);
    chk("abort_result", bus.result, 16'h0068);
    chk("abort_mismatch", 16'(bus.mismatch_cnt), 16'd0);
    chk("abort_pass", 16'(bus.pass), 16'd0);
    seen_done = 1'b0;
    repeat (LAST) begin
      if (bus.done) seen_done = 1'b1;
      tick;
    end
    chk("abort_no_done", 16'(seen_done), 16'd0);

    // Reset in the DRIVE cycle of vector 5, then a clean sweep.
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (5 * PER) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", 16'(bus.busy), 16'd0);
    chk("midrst_result", bus.result, 16'd0);
    chk("midrst_mismatch", 16'(bus.mismatch_cnt), 16'd0);
    chk("midrst_abc", 16'({bus.A, bus.B, bus.C}), 16'd0);
    run_sweep(16'hD668, 16'hD668, 4'd0, 1'b1);

    // Randomized truth tables, goldens, and start/abort/rst traffic.
    for (int i = 0; i < 40; i++) begin
      circ = (i % 4 == 0) ? CANON : 16'($urandom);
      bus.expected = ($urandom_range(0, 2) == 0) ? circ : 16'($urandom);
      repeat ($urandom_range(0, 3)) tick;
      bus.start = 1'b1;
      bus.abort = ($urandom_range(0, 3) == 0);
      tick;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int c = 0; c < LAST + 3; c++) begin
        bus.start = ($urandom_range(0, 7) == 0);
        bus.abort = ($urandom_range(0, 39) == 0);
        rst = ($urandom_range(0, 199) == 0);
        tick;
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst = 1'b0;
      tick;
    end
    repeat (LAST + 2) tick;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
